// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the instruction fetch stage.
// Contents:
//   OP_J / OP_JAL  opcode field values (bits [15:13]) of the direct jumps
//   NOP            instruction word placed in IF/ID as a bubble
//   estado_t       fetch FSM states (INICIO, BUSCA, FORA)
//   eh_salto       true when a word is a direct jump (j or jal)
//   alvo_salto     byte target of a direct jump
package mips_pkg;

  localparam logic [2:0]  OP_J   = 3'b110;
  localparam logic [2:0]  OP_JAL = 3'b111;
  localparam logic [15:0] NOP    = 16'd0;

  typedef enum logic [1:0] {
    INICIO = 2'b00,
    BUSCA  = 2'b01,
    FORA   = 2'b10
  } estado_t;

  // Direct jumps are recognised from the opcode field alone.
  function automatic logic eh_salto(input logic [2:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

  // Target keeps the 16 KiB region of pc+2 and replaces the rest with the
  // 13-bit word index shifted to a byte address.
  function automatic logic [15:0] alvo_salto(input logic [1:0]  regiao,
                                             input logic [12:0] indice);
    return {regiao, indice, 1'b0};
  endfunction

endpackage

// File: rtl/registrador_if_id.sv
// registrador_if_id -- IF/ID pipeline register.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset_n      synchronous active-low reset
//   i_descarta     write a bubble (valid=0, NOP, pc+2=0); wins over i_carrega
//   i_carrega      load a fetched instruction with valid=1
//   i_instrucao    fetched instruction word
//   i_pc_mais2     fetch pc + 2
//   o_valid        register holds a real instruction
//   o_instrucao    registered instruction (NOP when invalid)
//   o_pc_mais2     registered pc + 2
// With neither i_descarta nor i_carrega the register holds its contents.
module registrador_if_id
  import mips_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_descarta,
  input  logic        i_carrega,
  input  logic [15:0] i_instrucao,
  input  logic [15:0] i_pc_mais2,
  output logic        o_valid,
  output logic [15:0] o_instrucao,
  output logic [15:0] o_pc_mais2
);

  logic        r_valid;
  logic [15:0] r_instrucao;
  logic [15:0] r_pc_mais2;

  // Pipeline register: reset, flush to bubble, load, or hold.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_valid     <= 1'b0;
      r_instrucao <= NOP;
      r_pc_mais2  <= 16'd0;
    end else if (i_descarta) begin
      r_valid     <= 1'b0;
      r_instrucao <= NOP;
      r_pc_mais2  <= 16'd0;
    end else if (i_carrega) begin
      r_valid     <= 1'b1;
      r_instrucao <= i_instrucao;
      r_pc_mais2  <= i_pc_mais2;
    end else begin
      r_valid     <= r_valid;
      r_instrucao <= r_instrucao;
      r_pc_mais2  <= r_pc_mais2;
    end
  end

  assign o_valid     = r_valid;
  assign o_instrucao = r_instrucao;
  assign o_pc_mais2  = r_pc_mais2;

endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao -- instruction fetch stage with IF/ID register.
// Parameter:
//   LIMITE_PC     first byte address outside instruction memory
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   stall         hazard hold from decode (freezes pc and IF/ID)
//   redirect      taken branch / jr from a later stage (flushes IF/ID)
//   redirect_pc   redirect byte target (bit 0 ignored)
//   instrucao     instruction memory word at pc (combinational)
//   pc            current fetch byte address
//   if_valid      IF/ID holds a real instruction
//   if_instrucao  IF/ID instruction word (NOP when invalid)
//   if_pc_mais2   IF/ID copy of fetch pc + 2
//   fora_limite   high while the fetch FSM is in FORA
//   contador      number of instructions delivered with if_valid=1
module busca_instrucao
  import mips_pkg::*;
#(
  parameter logic [15:0] LIMITE_PC = 16'd128
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] instrucao,
  output logic [15:0] pc,
  output logic        if_valid,
  output logic [15:0] if_instrucao,
  output logic [15:0] if_pc_mais2,
  output logic        fora_limite,
  output logic [15:0] contador
);

  estado_t     r_estado;
  logic [15:0] r_pc;
  logic [15:0] r_contador;
  logic        r_fora_limite;

  estado_t     w_prox_estado;
  logic [15:0] w_prox_pc;
  logic [15:0] w_pc_mais2;
  logic [15:0] w_pc_seq;
  logic [15:0] w_redirect_alvo;
  logic        w_carrega;
  logic        w_descarta;

  // pc+2 wraps naturally in 16 bits.
  assign w_pc_mais2      = r_pc + 16'd2;
  assign w_redirect_alvo = redirect_pc & 16'hFFFE;
  assign w_pc_seq        = eh_salto(instrucao[15:13])
                           ? alvo_salto(w_pc_mais2[15:14], instrucao[12:0])
                           : w_pc_mais2;

  // Next-state, next-pc and IF/ID control decode.
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_pc     = r_pc;
    w_carrega     = 1'b0;
    w_descarta    = 1'b0;
    if (redirect) begin
      // Redirect beats stall and also the only way out of FORA.
      w_prox_pc     = w_redirect_alvo;
      w_prox_estado = (w_redirect_alvo >= LIMITE_PC) ? FORA : BUSCA;
      w_descarta    = 1'b1;
    end else begin
      case (r_estado)
        INICIO: begin
          w_prox_estado = BUSCA;
          w_descarta    = 1'b1;
        end
        BUSCA: begin
          if (!stall) begin
            w_carrega     = 1'b1;
            w_prox_pc     = w_pc_seq;
            w_prox_estado = (w_pc_seq >= LIMITE_PC) ? FORA : BUSCA;
          end else begin
            w_prox_pc     = r_pc;
            w_prox_estado = BUSCA;
          end
        end
        FORA: begin
          // A stalled decode keeps the last instruction it was given.
          if (!stall) begin
            w_descarta = 1'b1;
          end else begin
            w_descarta = 1'b0;
          end
        end
        default: begin
          w_prox_estado = INICIO;
          w_descarta    = 1'b1;
        end
      endcase
    end
  end

  // Fetch FSM state, pc, delivered-instruction counter and limit flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_estado      <= INICIO;
      r_pc          <= 16'd0;
      r_contador    <= 16'd0;
      r_fora_limite <= 1'b0;
    end else begin
      r_estado      <= w_prox_estado;
      r_pc          <= w_prox_pc;
      r_fora_limite <= (w_prox_estado == FORA);
      if (w_carrega) begin
        r_contador <= r_contador + 16'd1;
      end else begin
        r_contador <= r_contador;
      end
    end
  end

  registrador_if_id u_if_id (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_descarta  (w_descarta),
    .i_carrega   (w_carrega),
    .i_instrucao (instrucao),
    .i_pc_mais2  (w_pc_mais2),
    .o_valid     (if_valid),
    .o_instrucao (if_instrucao),
    .o_pc_mais2  (if_pc_mais2)
  );

  assign pc          = r_pc;
  assign fora_limite = r_fora_limite;
  assign contador    = r_contador;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

  localparam logic [15:0] LIM = 16'd128;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instrucao;
  logic [15:0] pc;
  logic        if_valid;
  logic [15:0] if_instrucao;
  logic [15:0] if_pc_mais2;
  logic        fora_limite;
  logic [15:0] contador;

  logic [15:0] mem [0:127];

  int tests_run = 0;
  int failed    = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_pc2, m_cnt;
  logic        m_valid, m_fora, m_started;

  always #5 clock = ~clock;

  // instruction memory answers combinationally for the DUT's pc
  always_comb instrucao = mem[pc[7:1]];

  busca_instrucao #(.LIMITE_PC(LIM)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instrucao(instrucao), .pc(pc),
    .if_valid(if_valid), .if_instrucao(if_instrucao), .if_pc_mais2(if_pc_mais2),
    .fora_limite(fora_limite), .contador(contador)
  );

  task automatic bolha();
    m_valid = 1'b0; m_instr = 16'd0; m_pc2 = 16'd0;
  endtask

  // advance the model by one edge from the current inputs, then clock the DUT
  task automatic ciclo();
    logic [15:0] w;
    logic [15:0] p2;
    if (!reset_n) begin
      m_pc = 16'd0; m_cnt = 16'd0; m_fora = 1'b0; m_started = 1'b0; bolha();
    end else if (redirect) begin
      m_pc = redirect_pc & 16'hFFFE; bolha();
      m_fora = (m_pc >= LIM); m_started = 1'b1;
    end else if (!m_started) begin
      bolha(); m_started = 1'b1;
    end else if (m_fora) begin
      if (!stall) bolha();
    end else if (!stall) begin
      w = mem[m_pc[7:1]];
      p2 = m_pc + 16'd2;
      m_valid = 1'b1; m_instr = w; m_pc2 = p2; m_cnt = m_cnt + 16'd1;
      if (w[15:14] == 2'b11) m_pc = (p2 & 16'hC000) | ((w & 16'h1FFF) << 1);
      else m_pc = p2;
      m_fora = (m_pc >= LIM);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040; reset_n = 1'b0;
    ciclo();
    tests_run++;
    if ({pc, if_valid, if_instrucao, if_pc_mais2, fora_limite, contador} !== 66'd0) begin
      failed++;
      $display("FAIL reset: pc=%h v=%b i=%h p2=%h f=%b c=%h, required all zero",
               pc, if_valid, if_instrucao, if_pc_mais2, fora_limite, contador);
    end
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
  endtask

  task automatic test_sequencial();
    mem[0] = 16'h2041; mem[1] = 16'h2082; mem[2] = 16'h20C3; mem[3] = 16'h2104;
    reset_n = 1'b0; ciclo(); reset_n = 1'b1;
    ciclo();
    tests_run++;
    if (pc !== 16'd0 || if_valid !== 1'b0 || contador !== 16'd0) begin
      failed++;
      $display("FAIL seq_inicio: pc=%h v=%b c=%h, required pc=0000 v=0 c=0000", pc, if_valid, contador);
    end
    ciclo();
    tests_run++;
    if (pc !== 16'd2 || if_valid !== 1'b1 || if_instrucao !== 16'h2041 ||
        if_pc_mais2 !== 16'd2 || contador !== 16'd1) begin
      failed++;
      $display("FAIL seq_fetch0: pc=%h v=%b i=%h p2=%h c=%h, required 0002 1 2041 0002 0001",
               pc, if_valid, if_instrucao, if_pc_mais2, contador);
    end
    ciclo();
    tests_run++;
    if (pc !== 16'd4 || if_instrucao !== 16'h2082) begin
      failed++;
      $display("FAIL seq_fetch1: pc=%h i=%h, required 0004 2082", pc, if_instrucao);
    end
    ciclo();
    tests_run++;
    if (pc !== 16'd6 || if_valid !== 1'b1 || if_instrucao !== 16'h20C3 ||
        if_pc_mais2 !== 16'd6 || contador !== 16'd3) begin
      failed++;
      $display("FAIL seq_fetch2: pc=%h v=%b i=%h p2=%h c=%h, required 0006 1 20c3 0006 0003",
               pc, if_valid, if_instrucao, if_pc_mais2, contador);
    end
  endtask

  task automatic test_salto();
    redirect = 1'b1; redirect_pc = 16'd36; ciclo(); redirect = 1'b0;
    tests_run++;
    if (pc !== 16'd36 || if_valid !== 1'b0 || if_instrucao !== 16'd0) begin
      failed++;
      $display("FAIL redirect36: pc=%h v=%b i=%h, required 0024 0 0000", pc, if_valid, if_instrucao);
    end
    mem[18] = 16'b1100000000000000;
    ciclo();
    tests_run++;
    if (pc !== 16'd0 || if_valid !== 1'b1 || if_instrucao !== 16'hC000 || if_pc_mais2 !== 16'd38) begin
      failed++;
      $display("FAIL jump_j: pc=%h v=%b i=%h p2=%h, required 0000 1 c000 0026",
               pc, if_valid, if_instrucao, if_pc_mais2);
    end
    redirect = 1'b1; redirect_pc = 16'd28; ciclo(); redirect = 1'b0;
    mem[14] = 16'b1110000000001001;
    ciclo();
    tests_run++;
    if (pc !== 16'd18 || if_valid !== 1'b1 || if_instrucao !== 16'hE009 || if_pc_mais2 !== 16'd30) begin
      failed++;
      $display("FAIL jump_jal: pc=%h v=%b i=%h p2=%h, required 0012 1 e009 001e",
               pc, if_valid, if_instrucao, if_pc_mais2);
    end
  endtask

  task automatic test_stall_redirect();
    logic [15:0] cnt_antes;
    cnt_antes = m_cnt;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0011;
    ciclo();
    redirect = 1'b0; stall = 1'b0;
    tests_run++;
    if (pc !== 16'h0010 || if_valid !== 1'b0 || if_instrucao !== 16'd0 || contador !== cnt_antes) begin
      failed++;
      $display("FAIL stall_redirect: pc=%h v=%b i=%h c=%h, required 0010 0 0000 %h",
               pc, if_valid, if_instrucao, contador, cnt_antes);
    end
    mem[8] = 16'h2345;
    ciclo();
    cnt_antes = m_cnt;
    stall = 1'b1; ciclo(); ciclo(); stall = 1'b0;
    tests_run++;
    if (pc !== 16'h0012 || if_valid !== 1'b1 || if_instrucao !== 16'h2345 ||
        if_pc_mais2 !== 16'h0012 || contador !== cnt_antes) begin
      failed++;
      $display("FAIL stall_hold: pc=%h v=%b i=%h p2=%h c=%h, required 0012 1 2345 0012 %h",
               pc, if_valid, if_instrucao, if_pc_mais2, contador, cnt_antes);
    end
  endtask

  task automatic test_fora();
    redirect = 1'b1; redirect_pc = 16'd120; ciclo(); redirect = 1'b0;
    mem[60] = 16'h2001; mem[61] = 16'h2002; mem[62] = 16'h2003; mem[63] = 16'h2004;
    ciclo(); ciclo(); ciclo();
    tests_run++;
    if (pc !== 16'd126 || fora_limite !== 1'b0) begin
      failed++;
      $display("FAIL fora_126: pc=%h f=%b, required 007e 0", pc, fora_limite);
    end
    ciclo();
    tests_run++;
    if (pc !== 16'd128 || fora_limite !== 1'b1 || if_valid !== 1'b1 ||
        if_instrucao !== 16'h2004 || if_pc_mais2 !== 16'd128) begin
      failed++;
      $display("FAIL fora_entra: pc=%h f=%b v=%b i=%h p2=%h, required 0080 1 1 2004 0080",
               pc, fora_limite, if_valid, if_instrucao, if_pc_mais2);
    end
    ciclo(); ciclo();
    tests_run++;
    if (pc !== 16'd128 || fora_limite !== 1'b1 || if_valid !== 1'b0 || if_instrucao !== 16'd0) begin
      failed++;
      $display("FAIL fora_bolha: pc=%h f=%b v=%b i=%h, required 0080 1 0 0000",
               pc, fora_limite, if_valid, if_instrucao);
    end
    redirect = 1'b1; redirect_pc = 16'd200; ciclo();
    tests_run++;
    if (pc !== 16'd200 || fora_limite !== 1'b1) begin
      failed++;
      $display("FAIL fora_redirect_fora: pc=%h f=%b, required 00c8 1", pc, fora_limite);
    end
    redirect_pc = 16'd0; ciclo(); redirect = 1'b0;
    tests_run++;
    if (pc !== 16'd0 || fora_limite !== 1'b0 || if_valid !== 1'b0) begin
      failed++;
      $display("FAIL fora_sai: pc=%h f=%b v=%b, required 0000 0 0", pc, fora_limite, if_valid);
    end
    mem[0] = 16'h2041;
    ciclo();
    tests_run++;
    if (pc !== 16'd2 || if_valid !== 1'b1 || if_instrucao !== 16'h2041) begin
      failed++;
      $display("FAIL fora_retoma: pc=%h v=%b i=%h, required 0002 1 2041", pc, if_valid, if_instrucao);
    end
  endtask

  task automatic test_reset_fora();
    redirect = 1'b1; redirect_pc = 16'd130; ciclo(); redirect = 1'b0;
    stall = 1'b1; ciclo();
    tests_run++;
    if (fora_limite !== 1'b1 || pc !== 16'd130) begin
      failed++;
      $display("FAIL reset_fora_pre: pc=%h f=%b, required 0082 1", pc, fora_limite);
    end
    reset_n = 1'b0; ciclo();
    tests_run++;
    if ({pc, if_valid, if_instrucao, if_pc_mais2, fora_limite, contador} !== 66'd0) begin
      failed++;
      $display("FAIL reset_fora: pc=%h v=%b i=%h p2=%h f=%b c=%h, required all zero",
               pc, if_valid, if_instrucao, if_pc_mais2, fora_limite, contador);
    end
    reset_n = 1'b1; stall = 1'b0;
  endtask

  task automatic test_aleatorio();
    logic [65:0] obs, esp;
    int erros;
    erros = 0;
    for (int k = 0; k < 128; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op >= 3'd6) mem[k] = {op, 13'($urandom_range(0, 70))};
      else mem[k] = {op, 13'($urandom)};
    end
    for (int n = 0; n < 600; n++) begin
      reset_n     = ($urandom_range(0, 99) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = 16'($urandom_range(0, 150));
      ciclo();
      obs = {pc, if_valid, if_instrucao, if_pc_mais2, fora_limite, contador};
      esp = {m_pc, m_valid, m_instr, m_pc2, m_fora, m_cnt};
      tests_run++;
      if (obs !== esp) begin
        failed++;
        if (erros < 10)
          $display("FAIL random[%0d]: got {pc,v,i,p2,f,c}=%h, required %h", n, obs, esp);
        erros++;
      end
    end
    reset_n = 1'b1; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 16'h2000;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
    m_pc = 16'd0; m_instr = 16'd0; m_pc2 = 16'd0; m_cnt = 16'd0;
    m_valid = 1'b0; m_fora = 1'b0; m_started = 1'b0;
    #2;
    test_reset();
    test_sequencial();
    test_salto();
    test_stall_redirect();
    test_fora();
    test_reset_fora();
    test_aleatorio();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
